// File: rtl/trackball_multi.sv
// N-axis trackball emulator: mouse packets, digital joystick and analog stick feed saturating
// per-axis step accumulators that drain as tb_dir/tb_clk steps. Optional: TRACKBALL_IDLE_CLR_EN.
module trackball_multi #(
  parameter int AXES        = 2,
  parameter int ACC_W       = 10,
  parameter int STEP_DIV    = 1000,
  parameter int JOY_DIV_LO  = 40000,
  parameter int JOY_DIV_HI  = 20000,
  parameter int IDLE_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mouse_strobe,
  input  logic [AXES*9-1:0]    mouse_dx,
  input  logic [1:0]           mouse_speed,
  input  logic [AXES*2-1:0]    joystick,
  input  logic                 joystick_mode,
  input  logic [AXES*8-1:0]    joystick_analog,
  input  logic                 joystick_sensitivity,
  input  logic                 flip,
  output logic [AXES-1:0]      tb_dir,
  output logic [AXES-1:0]      tb_clk
);

  // Working width holds acc + doubled mouse delta + joystick term without overflow before clamping.
  localparam int SW      = ((ACC_W > 11) ? ACC_W : 11) + 2;
  localparam int STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int JOY_MAX = (JOY_DIV_LO > JOY_DIV_HI) ? JOY_DIV_LO : JOY_DIV_HI;
  localparam int JOY_W   = (JOY_MAX > 1) ? $clog2(JOY_MAX) : 1;

  localparam logic signed [SW-1:0] ACC_MAX = SW'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SW-1:0] ONE_P   = SW'(1);
  localparam logic signed [SW-1:0] ONE_N   = SW'(-1);

  if (AXES < 1 || ACC_W < 2 || STEP_DIV < 1 || JOY_DIV_LO < 1 || JOY_DIV_HI < 1 || IDLE_CYCLES < 1)
  begin : g_bad_params
    $error("trackball_multi: invalid parameter values");
  end

  logic              shadow;
  logic              primed;
  logic              packet;
  logic [STEP_W-1:0] step_cnt;
  logic              step_wrap;
  logic [JOY_W-1:0]  joy_cnt;
  logic [JOY_W-1:0]  joy_lim;
  logic              joy_wrap;
  logic              joy_sens_q;

  assign packet    = primed && (mouse_strobe != shadow);
  assign step_wrap = (step_cnt == STEP_W'(STEP_DIV - 1));
  assign joy_lim   = joy_sens_q ? JOY_W'(JOY_DIV_HI - 1) : JOY_W'(JOY_DIV_LO - 1);
  assign joy_wrap  = (joy_cnt == joy_lim);

  // The joystick divisor is latched at each wrap so a sensitivity change never strands the counter above its limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
      shadow     <= 1'b0;
      primed     <= 1'b0;
      step_cnt   <= '0;
      joy_cnt    <= '0;
      joy_sens_q <= 1'b0;
    end else begin
      shadow <= mouse_strobe;
      primed <= 1'b1;
      step_cnt <= step_wrap ? '0 : step_cnt + STEP_W'(1);
      if (joy_wrap) begin
        joy_cnt    <= '0;
        joy_sens_q <= joystick_sensitivity;
      end else begin
        joy_cnt <= joy_cnt + JOY_W'(1);
      end
    end
  end

  for (genvar g = 0; g < AXES; g++) begin : g_axis
    logic signed [8:0]       dx;
    logic signed [7:0]       an;
    logic signed [SW-1:0]    dx_w;
    logic signed [SW-1:0]    an_w;
    logic signed [SW-1:0]    acc_w;
    logic signed [SW-1:0]    mouse_term;
    logic signed [SW-1:0]    joy_term;
    logic signed [SW-1:0]    step_term;
    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    sat;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic                    acc_pos;
    logic                    emit;
    logic                    force_zero;
    logic                    dir_q;
    logic                    clk_q;

    assign dx      = mouse_dx[9*g +: 9];
    assign an      = joystick_analog[8*g +: 8];
    assign dx_w    = {{(SW-9){dx[8]}}, dx};
    assign an_w    = {{(SW-8){an[7]}}, an};
    assign acc_w   = {{(SW-ACC_W){acc[ACC_W-1]}}, acc};
    assign acc_pos = !acc[ACC_W-1] && (acc != '0);
    assign emit    = step_wrap && (acc != '0);

    always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      mouse_term = '0;
      joy_term   = '0;
      step_term  = '0;
      if (packet) begin
        case (mouse_speed)
          2'd0:    mouse_term = dx_w >>> 2;
          2'd1:    mouse_term = dx_w >>> 1;
          2'd2:    mouse_term = dx_w;
          default: mouse_term = dx_w <<< 1;
        endcase
      end
      if (joy_wrap) begin
        if (joystick_mode) begin
          if (an >= 8'sd16 || an <= -8'sd16) joy_term = an_w >>> 4;
        end else begin
          case (joystick[2*g +: 2])
            2'b01:   joy_term = ONE_P;
            2'b10:   joy_term = ONE_N;
            default: joy_term = '0;
          endcase
        end
      end
      if (emit) step_term = acc_pos ? ONE_P : ONE_N;
      // All same-cycle contributions are summed first so the clamp is applied exactly once.
      sum = acc_w + mouse_term + joy_term - step_term;
      if (sum > ACC_MAX)      sat = ACC_MAX;
      else if (sum < ACC_MIN) sat = ACC_MIN;
      else                    sat = sum;
      acc_next = sat[ACC_W-1:0];
    end

`ifdef TRACKBALL_IDLE_CLR_EN
    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_clr;
    logic              idle_hit;

    assign idle_clr   = packet || (joy_term != '0);
    assign idle_hit   = (idle_cnt == IDLE_W'(IDLE_CYCLES));
    assign force_zero = idle_hit && !idle_clr;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)          idle_cnt <= '0;
      else if (idle_clr)  idle_cnt <= '0;
      else if (!idle_hit) idle_cnt <= idle_cnt + IDLE_W'(1);
    end
`else
    assign force_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc   <= '0;
        dir_q <= 1'b0;
        clk_q <= 1'b0;
      end else begin
        acc <= force_zero ? '0 : acc_next;
        if (emit) begin
          dir_q <= acc_pos ^ flip;
          clk_q <= ~clk_q;
        end
      end
    end

    assign tb_dir[g] = dir_q;
    assign tb_clk[g] = clk_q;
  end

endmodule

// File: tb/tb_trackball_multi.sv
// Scoreboard bench for trackball_multi: an arithmetic reference model queues expected steps,
// a negedge monitor pops them whenever a tb_clk edge appears.
module tb_trackball_multi;
  localparam int AXES       = 2;
  localparam int ACC_W      = 8;
  localparam int STEP_DIV   = 20;
  localparam int JOY_DIV_LO = 60;
  localparam int JOY_DIV_HI = 30;
  localparam int ACC_MAX    = (1 << (ACC_W - 1)) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                mouse_strobe = 1'b0;
  logic [AXES*9-1:0]   mouse_dx = '0;
  logic [1:0]          mouse_speed = '0;
  logic [AXES*2-1:0]   joystick = '0;
  logic                joystick_mode = 1'b0;
  logic [AXES*8-1:0]   joystick_analog = '0;
  logic                joystick_sensitivity = 1'b0;
  logic                flip = 1'b0;
  logic [AXES-1:0]     tb_dir;
  logic [AXES-1:0]     tb_clk;

  always #5 clk = ~clk;

  trackball_multi #(
    .AXES(AXES), .ACC_W(ACC_W), .STEP_DIV(STEP_DIV),
    .JOY_DIV_LO(JOY_DIV_LO), .JOY_DIV_HI(JOY_DIV_HI), .IDLE_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .mouse_strobe(mouse_strobe), .mouse_dx(mouse_dx),
    .mouse_speed(mouse_speed), .joystick(joystick), .joystick_mode(joystick_mode),
    .joystick_analog(joystick_analog), .joystick_sensitivity(joystick_sensitivity),
    .flip(flip), .tb_dir(tb_dir), .tb_clk(tb_clk)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model state: integer accumulators, counters and a queue of expected step directions.
  int m_acc [AXES];
  int m_step = 0;
  int m_joy = 0;
  int m_div = JOY_DIV_LO;
  bit m_shadow = 1'b0;
  bit m_primed = 1'b0;
  int cyc = 0;
  bit exp_q [AXES][$];

  initial begin
    for (int a = 0; a < AXES; a++) m_acc[a] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int a = 0; a < AXES; a++) begin
          m_acc[a] = 0;
          exp_q[a].delete();
        end
        m_step = 0; m_joy = 0; m_div = JOY_DIV_LO; m_shadow = 1'b0; m_primed = 1'b0;
      end else begin
        bit pkt, swrap, jwrap;
        int mt, jt, st, d, v, nxt;
        cyc++;
        pkt = m_primed && (mouse_strobe != m_shadow);
        m_shadow = mouse_strobe;
        m_primed = 1'b1;
        swrap = (m_step == STEP_DIV - 1);
        m_step = swrap ? 0 : m_step + 1;
        jwrap = (m_joy == m_div - 1);
        if (jwrap) begin
          m_joy = 0;
          m_div = joystick_sensitivity ? JOY_DIV_HI : JOY_DIV_LO;
        end else begin
          m_joy++;
        end
        for (int a = 0; a < AXES; a++) begin
          mt = 0; jt = 0; st = 0;
          if (pkt) begin
            d = $signed(mouse_dx[9*a +: 9]);
            case (mouse_speed)
              2'd0: mt = d >>> 2;
              2'd1: mt = d >>> 1;
              2'd2: mt = d;
              default: mt = d * 2;
            endcase
          end
          if (jwrap) begin
            if (joystick_mode) begin
              v = $signed(joystick_analog[8*a +: 8]);
              if (v >= 16 || v <= -16) jt = v >>> 4;
            end else if (joystick[2*a] && !joystick[2*a+1]) jt = 1;
            else if (joystick[2*a+1] && !joystick[2*a]) jt = -1;
          end
          if (swrap && m_acc[a] != 0) begin
            st = (m_acc[a] > 0) ? 1 : -1;
            exp_q[a].push_back((m_acc[a] > 0) ^ flip);
          end
          nxt = m_acc[a] + mt + jt - st;
          if (nxt > ACC_MAX) nxt = ACC_MAX;
          if (nxt < -ACC_MAX) nxt = -ACC_MAX;
          m_acc[a] = nxt;
        end
      end
    end
  end

  // Monitor: every tb_clk edge must match the next queued step and its direction.
  logic [AXES-1:0] prev_clk = '0;
  int last_t [AXES];
  int tog_cnt [AXES];
  int tog_neg [AXES];

  initial begin
    for (int a = 0; a < AXES; a++) begin
      last_t[a] = -1; tog_cnt[a] = 0; tog_neg[a] = 0;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_clk = tb_clk;
        for (int a = 0; a < AXES; a++) last_t[a] = -1;
      end else begin
        for (int a = 0; a < AXES; a++) begin
          if (tb_clk[a] !== prev_clk[a]) begin
            tog_cnt[a]++;
            if (tb_dir[a] == 1'b0) tog_neg[a]++;
            if (exp_q[a].size() == 0) begin
              check($sformatf("unexpected_step_ax%0d_cyc%0d", a, cyc), 1, 0);
            end else begin
              bit e;
              e = exp_q[a].pop_front();
              check($sformatf("step_dir_ax%0d_cyc%0d", a, cyc), int'(tb_dir[a]), int'(e));
            end
            if (last_t[a] >= 0)
              check($sformatf("step_spacing_ax%0d", a), (cyc - last_t[a]) % STEP_DIV, 0);
            last_t[a] = cyc;
          end
        end
        prev_clk = tb_clk;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input int dx0, input int dx1, input int spd);
    mouse_dx     = {9'(dx1), 9'(dx0)};
    mouse_speed  = 2'(spd);
    mouse_strobe = ~mouse_strobe;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (m_acc[0] == 0) && (m_acc[1] == 0) && (exp_q[0].size() == 0) && (exp_q[1].size() == 0);
    end
    check({name, "_drained"}, int'(done), 1);
    tick(2);
  endtask

  int s0, s1, n0, n1;

  task automatic snap();
    s0 = tog_cnt[0]; s1 = tog_cnt[1]; n0 = tog_neg[0]; n1 = tog_neg[1];
  endtask

  task automatic expect_steps(input string name, input int t0, input int neg0, input int t1, input int neg1);
    check({name, "_ax0_steps"}, tog_cnt[0] - s0, t0);
    check({name, "_ax0_neg"},   tog_neg[0] - n0, neg0);
    check({name, "_ax1_steps"}, tog_cnt[1] - s1, t1);
    check({name, "_ax1_neg"},   tog_neg[1] - n1, neg1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    tick(3);
    #1;
    check("reset_tb_dir", int'(tb_dir), 0);
    check("reset_tb_clk", int'(tb_clk), 0);
    reset = 1'b0;
    tick(3);

    snap(); send_pkt(5, 0, 2); drain("plus5");
    expect_steps("plus5", 5, 0, 0, 0);
    check("plus5_dir_held", int'(tb_dir[0]), 1);

    snap(); send_pkt(-3, 7, 0); drain("shift_neg");
    expect_steps("shift_neg", 1, 1, 1, 0);
    check("shift_neg_dir", int'(tb_dir[0]), 0);

    snap(); send_pkt(3, -4, 0); drain("shift_small");
    expect_steps("shift_small", 0, 0, 1, 1);

    snap(); send_pkt(100, -100, 3); drain("saturate");
    expect_steps("saturate", ACC_MAX, 0, ACC_MAX, ACC_MAX);

    snap(); joystick = 4'b0110; tick(3 * JOY_DIV_LO); joystick = '0; drain("joy_digital");
    expect_steps("joy_digital", 3, 3, 3, 0);

    snap(); joystick = 4'b1111; tick(3 * JOY_DIV_LO); joystick = '0; drain("joy_both");
    expect_steps("joy_both", 0, 0, 0, 0);

    joystick_mode = 1'b1;
    snap(); joystick_analog = {8'(-15), 8'(15)}; tick(3 * JOY_DIV_LO); joystick_analog = '0; drain("analog_dead");
    expect_steps("analog_dead", 0, 0, 0, 0);

    snap(); joystick_analog = {8'(16), 8'(-64)}; tick(2 * JOY_DIV_LO); joystick_analog = '0; drain("analog");
    expect_steps("analog", 8, 8, 2, 0);

    flip = 1'b1;
    snap(); joystick_analog = {8'(16), 8'(-64)}; tick(2 * JOY_DIV_LO); joystick_analog = '0; drain("analog_flip");
    expect_steps("analog_flip", 8, 0, 2, 2);
    flip = 1'b0;
    joystick_mode = 1'b0;

    // Packet lands on the same edge as a step-counter wrap while acc=+1.
    snap();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = (m_step == 0);
    end
    send_pkt(1, 0, 2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = (m_step == STEP_DIV - 1);
    end
    check("same_cycle_found_wrap", int'(found), 1);
    send_pkt(2, 0, 2);
    @(negedge clk);
    #1;
    check("same_cycle_first_step", tog_cnt[0] - s0, 1);
    drain("same_cycle");
    expect_steps("same_cycle", 3, 0, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        mouse_dx     = 18'($urandom);
        mouse_speed  = 2'($urandom);
        mouse_strobe = ~mouse_strobe;
      end
      if ($urandom_range(15) == 0)  joystick = 4'($urandom);
      if ($urandom_range(63) == 0)  joystick_mode = ~joystick_mode;
      if ($urandom_range(15) == 0)  joystick_analog = 16'($urandom);
      if ($urandom_range(127) == 0) joystick_sensitivity = ~joystick_sensitivity;
      if ($urandom_range(127) == 0) flip = ~flip;
    end
    joystick = '0; joystick_mode = 1'b0; joystick_analog = '0; joystick_sensitivity = 1'b0; flip = 1'b0;
    drain("random");

    snap(); send_pkt(50, -50, 2);
    tick(5 * STEP_DIV);
    check("mid_drain_started", tog_cnt[0] - s0, 5);
    reset = 1'b1;
    #1;
    check("mid_reset_tb_dir", int'(tb_dir), 0);
    check("mid_reset_tb_clk", int'(tb_clk), 0);
    tick(3);
    reset = 1'b0;
    snap();
    tick(10 * STEP_DIV);
    expect_steps("after_reset", 0, 0, 0, 0);
    check("after_reset_tb_clk", int'(tb_clk), 0);

    check("final_queue_ax0", exp_q[0].size(), 0);
    check("final_queue_ax1", exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
